serial_alu_unit: RTL and testbench
==================================

Name: serial_alu_unit

Overview:
Multi-cycle, parametrised Y86 integer ALU for the SEQ datapath. It performs add, subtract, and, or xor on WIDTH-bit operands. It processes CHUNK bits per clock through a ripple full-adder slice, so a wide datapath trades latency for area. At completion it produces the result plus Y86 condition codes (CF, OF, ZF, SF) under a start/ready/done handshake.

Parameters:
WIDTH, 64, operand/result width in bits.
CHUNK, 8, bits processed per cycle. WIDTH % CHUNK must be 0, otherwise elaboration error. NCHUNK = WIDTH/CHUNK.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous, active-high reset.
start  in  1  request. Sampled only when ready=1.
op  in  2  operation select: 0 ADD, 1 SUB, 2 AND, 3 XOR (Y86 ifun encoding).
a  in  WIDTH  operand A, sampled with start.
b  in  WIDTH  operand B, sampled with start. SUB computes a - b.
ready  out  1  high in IDLE and low while rst=1.
done  out  1  one-cycle pulse; result and flags are valid.
result  out  WIDTH  registered result. Holds until the next accepted start.
cf  out  1  carry-out of the MSB. For SUB, 1 means no borrow (a >= b unsigned). 0 for AND/XOR.
of  out  1  signed overflow = carry into MSB XOR carry out of MSB, ADD/SUB only. 0 for AND/XOR.
zf  out  1  result == 0.
sf  out  1  result[WIDTH-1].

Behaviour:
- States are IDLE, RUN, DONE. Reset drives IDLE with result, cf, of, zf, sf and done all 0. rst has priority over every other input, including mid-RUN. An aborted operation never raises done.
- IDLE: on an edge with start=1:
  - latch a, op, and b_eff (b_eff = ~b for SUB, else b).
  - set carry = 1 for SUB, else 0.
  - set chunk index k = 0 and the running zero accumulator = 1.
  - go to RUN.
- RUN: each edge processes slice [k*CHUNK +: CHUNK]:
  - ADD/SUB: slice sum from the chunk_adder using the carry register; carry-out is stored for the next slice.
  - AND/XOR: bitwise on a and b (unmodified).
  - Write the slice into result. AND the zero accumulator with (slice == 0).
  - k increments. At the edge where k == NCHUNK-1, latch the flags (of from the final slice's MSB carries) and go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. ready=0 in RUN and DONE.
- Latency: start accepted at edge E. done is high in the cycle beginning at edge E+NCHUNK. The next start can be accepted at edge E+NCHUNK+2.
- start while ready=0 is ignored, not queued. Operand changes after the accept edge have no effect.
- Wrap-around: arithmetic is modulo 2^WIDTH. Overflow is reported only via cf/of.
- Flags and result stay stable after done until the next accept edge, where they may begin changing.

Decomposition:
- Package alu_pkg: op encodings ALU_ADD=2'd0, ALU_SUB=2'd1, ALU_AND=2'd2, ALU_XOR=2'd3; state encoding localparams.
- Sub-module chunk_adder, parameter W: W-bit ripple of full adders. Inputs x, y, cin. Outputs s, cout, and c_msb (carry into bit W-1) for the OF computation.
- Top module: FSM, chunk counter of $clog2(NCHUNK)+1 bits, operand and result registers.

Test Plan:
1. WIDTH=64, CHUNK=8, ADD a=5, b=3 at edge E -> done only in cycle E+8; result=8; cf=0, of=0, zf=0, sf=0; ready returns at E+9.
2. SUB a=5, b=5 -> result=0, zf=1, cf=1, of=0, sf=0. SUB a=3, b=5 -> result=0xFFFF_FFFF_FFFF_FFFE, cf=0, sf=1, of=0.
3. SUB a=0x8000_0000_0000_0000, b=1 -> result=0x7FFF_FFFF_FFFF_FFFF, of=1, cf=1, sf=0. ADD 0x7FFF_FFFF_FFFF_FFFF+1 -> 0x8000_0000_0000_0000, of=1, sf=1, cf=0.
4. ADD 0xFFFF_FFFF_FFFF_FFFF+1 -> result=0, cf=1, zf=1, of=0. AND a=0xF0F0, b=0xFF00 -> 0xF000, cf=0, of=0. XOR a=b=0x1234 -> 0, zf=1.
5. Handshake:
   - start held high during RUN with different operands -> ignored; the first result is unchanged.
   - rst asserted at edge E+3 of a run -> all outputs 0, no done pulse; ready=1 the cycle after rst falls.
6. Parameter sweep: CHUNK=64 -> done at E+1; CHUNK=16 -> done at E+4; WIDTH=32, CHUNK=4 -> done at E+8. Run a random ADD/SUB/AND/XOR sweep against a reference model, including carries across chunk boundaries (a=0x00FF, b=0x0001).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the serial Y86 ALU: operation codes and FSM states.
package alu_pkg;

  // Y86 ifun encoding of the ALU operation
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_XOR = 2'd3;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } alu_state_t;

  // ADD and SUB use the adder and report carry/overflow; logic ops do not
  function automatic logic op_is_arith(input logic [1:0] op_i);
    return (op_i == ALU_ADD) || (op_i == ALU_SUB);
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// W-bit ripple-carry adder slice. Also exposes the carry into the top bit so
// the caller can form signed overflow from the final slice.
module chunk_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb
);

  logic [W:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]       = x[i] ^ y[i] ^ w_c[i];
    assign w_c[i + 1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
  end

  assign cout  = w_c[W];
  assign c_msb = w_c[W-1];

endmodule

// File: rtl/serial_alu_unit.sv
// Multi-cycle Y86 ALU. Operands are consumed CHUNK bits per clock from the
// bottom of two shift registers; each computed slice is shifted into the top
// of the result register, so after NCHUNK slices the result is in place.
module serial_alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cf,
  output logic             of,
  output logic             zf,
  output logic             sf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = $clog2(NCHUNK) + 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
    $error("serial_alu_unit: WIDTH must be a non-zero multiple of CHUNK");
  end

  alu_state_t       r_state;
  alu_state_t       w_state_nxt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;          // holds ~b for SUB so the adder only adds
  logic             r_carry;
  logic [KW-1:0]    r_k;
  logic             r_zacc;       // all slices so far were zero
  logic [WIDTH-1:0] r_result;
  logic             r_cf;
  logic             r_of;
  logic             r_zf;
  logic             r_sf;
  logic             r_done;

  logic [CHUNK-1:0] w_a_sl;
  logic [CHUNK-1:0] w_b_sl;
  logic [CHUNK-1:0] w_sum;
  logic [CHUNK-1:0] w_slice;
  logic             w_cout;
  logic             w_cmsb;
  logic             w_last;
  logic             w_arith;
  logic             w_slice_zero;

  assign w_a_sl       = r_a[CHUNK-1:0];
  assign w_b_sl       = r_b[CHUNK-1:0];
  assign w_last       = (r_k == K_LAST);
  assign w_arith      = op_is_arith(r_op);
  assign w_slice_zero = (w_slice == {CHUNK{1'b0}});

  chunk_adder #(.W(CHUNK)) u_chunk_adder (
    .x     (w_a_sl),
    .y     (w_b_sl),
    .cin   (r_carry),
    .s     (w_sum),
    .cout  (w_cout),
    .c_msb (w_cmsb)
  );

  // Select the slice value produced by the current operation
  always_comb begin
    w_slice = w_sum;
    case (r_op)
      ALU_ADD: w_slice = w_sum;
      ALU_SUB: w_slice = w_sum;
      ALU_AND: w_slice = w_a_sl & w_b_sl;
      ALU_XOR: w_slice = w_a_sl ^ w_b_sl;
      default: w_slice = w_sum;
    endcase
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> DONE after the last slice
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture, per-slice datapath and flag latching
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= ALU_ADD;
      r_a      <= {WIDTH{1'b0}};
      r_b      <= {WIDTH{1'b0}};
      r_carry  <= 1'b0;
      r_k      <= {KW{1'b0}};
      r_zacc   <= 1'b0;
      r_result <= {WIDTH{1'b0}};
      r_cf     <= 1'b0;
      r_of     <= 1'b0;
      r_zf     <= 1'b0;
      r_sf     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_op    <= op;
            r_a     <= a;
            r_b     <= (op == ALU_SUB) ? ~b : b;
            r_carry <= (op == ALU_SUB);
            r_k     <= {KW{1'b0}};
            r_zacc  <= 1'b1;
          end
        end
        S_RUN: begin
          r_a      <= r_a >> CHUNK;
          r_b      <= r_b >> CHUNK;
          r_carry  <= w_cout;
          r_k      <= r_k + KW'(1);
          r_zacc   <= r_zacc & w_slice_zero;
          r_result <= (r_result >> CHUNK) | (WIDTH'(w_slice) << (WIDTH - CHUNK));
          if (w_last) begin
            r_cf   <= w_arith & w_cout;
            r_of   <= w_arith & (w_cout ^ w_cmsb);
            r_zf   <= r_zacc & w_slice_zero;
            r_sf   <= w_slice[CHUNK-1];
            r_done <= 1'b1;
          end
        end
        S_DONE: begin
          r_done <= 1'b0;
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

  // ready must drop in the same cycle rst rises, so it also looks at rst
  assign ready  = (r_state == S_IDLE) && !rst;
  assign done   = r_done;
  assign result = r_result;
  assign cf     = r_cf;
  assign of     = r_of;
  assign zf     = r_zf;
  assign sf     = r_sf;

endmodule

// File: tb/tb_serial_alu_unit.sv
// Scoreboard bench: four ALU instances with different WIDTH/CHUNK run the
// same stimulus; each accepted operation pushes a reference result that is
// popped and compared when that instance pulses done.
module tb_serial_alu_unit;
  import alu_pkg::*;

  typedef struct packed {
    logic [63:0] res;
    logic        cf;
    logic        of;
    logic        zf;
    logic        sf;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [63:0] a;
  logic [63:0] b;
  logic [3:0]  done_v, rdy_v, cf_v, of_v, zf_v, sf_v;
  logic [63:0] res0, res1, res2;
  logic [31:0] res3;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // accepted-operation hand-off to the per-instance monitors
  int          acc_seq = 0;
  int          flush_seq = 0;
  logic [1:0]  acc_op;
  logic [63:0] acc_a, acc_b;
  int          acc_cyc;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  serial_alu_unit #(.WIDTH(64), .CHUNK(8)) u_d0 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .ready(rdy_v[0]), .done(done_v[0]), .result(res0),
    .cf(cf_v[0]), .of(of_v[0]), .zf(zf_v[0]), .sf(sf_v[0]));

  serial_alu_unit #(.WIDTH(64), .CHUNK(64)) u_d1 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .ready(rdy_v[1]), .done(done_v[1]), .result(res1),
    .cf(cf_v[1]), .of(of_v[1]), .zf(zf_v[1]), .sf(sf_v[1]));

  serial_alu_unit #(.WIDTH(64), .CHUNK(16)) u_d2 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .ready(rdy_v[2]), .done(done_v[2]), .result(res2),
    .cf(cf_v[2]), .of(of_v[2]), .zf(zf_v[2]), .sf(sf_v[2]));

  serial_alu_unit #(.WIDTH(32), .CHUNK(4)) u_d3 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a[31:0]), .b(b[31:0]),
    .ready(rdy_v[3]), .done(done_v[3]), .result(res3),
    .cf(cf_v[3]), .of(of_v[3]), .zf(zf_v[3]), .sf(sf_v[3]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Reference: plain wide arithmetic, overflow from operand/result signs
  function automatic exp_t ref_alu(input logic [1:0] o, input logic [63:0] x,
                                   input logic [63:0] y, input int w);
    exp_t        e;
    logic [64:0] full;
    logic [63:0] m, xx, yy;
    logic        sx, sy, sr;
    e    = '0;
    m    = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    xx   = x & m;
    yy   = y & m;
    case (o)
      ALU_ADD: full = {1'b0, xx} + {1'b0, yy};
      ALU_SUB: full = {1'b0, xx} + {1'b0, (~yy) & m} + 65'd1;
      ALU_AND: full = {1'b0, xx & yy};
      default: full = {1'b0, xx ^ yy};
    endcase
    e.res = full[63:0] & m;
    sx = xx[w-1];
    sy = yy[w-1];
    sr = e.res[w-1];
    if (o == ALU_ADD) begin
      e.cf = full[w];
      e.of = (sx == sy) && (sr != sx);
    end else if (o == ALU_SUB) begin
      e.cf = full[w];
      e.of = (sx != sy) && (sr != sx);
    end else begin
      e.cf = 1'b0;
      e.of = 1'b0;
    end
    e.zf = (e.res == 64'd0);
    e.sf = sr;
    return e;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_mon
    localparam int W = (g == 3) ? 32 : 64;
    localparam int N = (g == 0) ? 8 : (g == 1) ? 1 : (g == 2) ? 4 : 8;
    exp_t q[$];
    int   seen_acc = 0;
    int   seen_flush = 0;
    logic chk_rdy = 1'b0;
    wire [63:0] w_res = (g == 0) ? res0 : (g == 1) ? res1 : (g == 2) ? res2 : {32'h0, res3};

    // Single owner of this instance's queue: flush, push, then compare on done
    always @(negedge clk) begin
      exp_t e;
      if (flush_seq != seen_flush) begin
        q.delete();
        seen_flush = flush_seq;
      end
      if (acc_seq != seen_acc) begin
        e = ref_alu(acc_op, acc_a, acc_b, W);
        e.cyc = acc_cyc;
        q.push_back(e);
        seen_acc = acc_seq;
      end
      if (chk_rdy) begin
        if (!rst) chk($sformatf("d%0d_ready_after_done", g), 64'(rdy_v[g]), 64'd1);
        chk_rdy = 1'b0;
      end
      if (done_v[g]) begin
        if (q.size() == 0) begin
          chk($sformatf("d%0d_spurious_done", g), 64'(done_v[g]), 64'd0);
        end else begin
          e = q.pop_front();
          chk($sformatf("d%0d_result", g), w_res, e.res);
          chk($sformatf("d%0d_cf", g), 64'(cf_v[g]), 64'(e.cf));
          chk($sformatf("d%0d_of", g), 64'(of_v[g]), 64'(e.of));
          chk($sformatf("d%0d_zf", g), 64'(zf_v[g]), 64'(e.zf));
          chk($sformatf("d%0d_sf", g), 64'(sf_v[g]), 64'(e.sf));
          chk($sformatf("d%0d_latency", g), 64'(cyc - e.cyc), 64'(N));
          chk($sformatf("d%0d_ready_in_done", g), 64'(rdy_v[g]), 64'd0);
          chk_rdy = 1'b1;
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while ((rdy_v != 4'hF) && (n < 300)) begin
      @(negedge clk);
      n++;
    end
    if (rdy_v != 4'hF) chk("ready_timeout", 64'(rdy_v), 64'hF);
  endtask

  task automatic note_accept(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
    acc_op  = o;
    acc_a   = x;
    acc_b   = y;
    acc_cyc = cyc;
    acc_seq++;
  endtask

  // Drive one operation; optionally keep start high with junk operands
  task automatic issue(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                       input int hold);
    wait_ready();
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    note_accept(o, x, y);
    for (int i = 0; i < hold; i++) begin
      op = o + 2'd1;
      a  = ~x;
      b  = x ^ 64'h5A5A_5A5A_5A5A_5A5A;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op    = ALU_ADD;
    a     = 64'd0;
    b     = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_result", res0, 64'd0);
    chk("rst_flags_done", {cf_v, of_v, zf_v, sf_v, done_v}, 64'd0);
    chk("rst_ready_low", 64'(rdy_v), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    issue(ALU_ADD, 64'd5, 64'd3, 0);
    issue(ALU_SUB, 64'd5, 64'd5, 0);
    issue(ALU_SUB, 64'd3, 64'd5, 0);
    issue(ALU_SUB, 64'h8000_0000_0000_0000, 64'd1, 0);
    issue(ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0);
    issue(ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
    issue(ALU_AND, 64'hF0F0, 64'hFF00, 0);
    issue(ALU_XOR, 64'h1234, 64'h1234, 0);
    issue(ALU_ADD, 64'h00FF, 64'h0001, 2);
    issue(ALU_ADD, 64'h0000_FFFF_FFFF_FFFF, 64'd1, 2);
    issue(ALU_SUB, 64'h0001_0000_0000_0000, 64'd1, 0);

    // Abort mid-run: reset sampled at the third edge after accept
    wait_ready();
    start = 1'b1;
    op    = ALU_ADD;
    a     = 64'h1111_2222_3333_4444;
    b     = 64'h0F0F_0F0F_0F0F_0F0F;
    @(posedge clk);
    #1;
    note_accept(ALU_ADD, 64'h1111_2222_3333_4444, 64'h0F0F_0F0F_0F0F_0F0F);
    start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    flush_seq++;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort_result", res0, 64'd0);
    chk("abort_flags_done", {cf_v, of_v, zf_v, sf_v, done_v}, 64'd0);
    chk("abort_ready_low", 64'(rdy_v), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_after_rst", 64'(rdy_v[0]), 64'd1);

    for (int i = 0; i < 40; i++) begin
      logic [63:0] x, y;
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      if ((i % 5) == 0) begin
        x = 64'h00FF_00FF_00FF_00FF;
        y = 64'd1 << (8 * (i % 8));
      end
      issue(2'($urandom_range(0, 3)), x, y, (i % 3 == 0) ? 1 : 0);
    end

    wait_ready();
    repeat (3) @(negedge clk);
    chk("d0_queue_drained", 64'(g_mon[0].q.size()), 64'd0);
    chk("d1_queue_drained", 64'(g_mon[1].q.size()), 64'd0);
    chk("d2_queue_drained", 64'(g_mon[2].q.size()), 64'd0);
    chk("d3_queue_drained", 64'(g_mon[3].q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
